bus_arbiter: RTL and testbench

//   Shares the single CPU bus between N_MST masters (IF fetch, MEM load/store, DMA, debug).

---
 rtl/cpu_bus_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_pick.sv | 50 +++++
 rtl/bus_arbiter.sv | 89 ++++++++
 tb/tb_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: master indices, arbiter state type, index type.
package cpu_bus_pkg;

  localparam int BUS_N_MST   = 4;
  localparam int BUS_MST_IF  = 0;
  localparam int BUS_MST_MEM = 1;
  localparam int BUS_MST_DMA = 2;
  localparam int BUS_MST_DBG = 3;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  typedef logic [2:0] bus_mst_t;

  // Index following 'idx' in a ring of 'n' masters.
  function automatic bus_mst_t bus_next_idx(input bus_mst_t idx, input int n);
    bus_mst_t res;
    if (idx == bus_mst_t'(n - 1))
      res = '0;
    else
      res = idx + 3'd1;
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after 'start', wrapping
// modulo N, optionally skipping one excluded index.
module rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int N = BUS_N_MST
) (
  input  logic [N-1:0] req,
  input  bus_mst_t     start,
  input  bus_mst_t     excl,
  input  logic         excl_en,
  output logic         found,
  output bus_mst_t     winner
);

  logic [N-1:0]   excl_mask;
  logic [N-1:0]   elig;
  logic [2*N-1:0] dbl_sh;
  logic [N-1:0]   rot;
  logic [3:0]     sum;
  logic [3:0]     wrapped;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_excl
      assign excl_mask[gi] = excl_en && (excl == bus_mst_t'(gi));
    end
  endgenerate

  assign elig   = req & ~excl_mask;
  // Rotate so that bit 0 of 'rot' corresponds to the start position.
  assign dbl_sh = {elig, elig} >> start;
  assign rot    = dbl_sh[N-1:0];

  // Lowest set bit of the rotated vector is the winner's offset from start.
  always_comb begin
    found   = 1'b0;
    sum     = '0;
    wrapped = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, start} + 4'(i);
      end
    end
    wrapped = (sum >= 4'(N)) ? (sum - 4'(N)) : sum;
    winner  = wrapped[2:0];
  end

endmodule

// File: rtl/bus_arbiter.sv
// CPU bus arbiter: registered round-robin grant, ownership held while the
// owner keeps requesting, optional hold limit forcing handover to waiters.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int N_MST    = BUS_N_MST,
  parameter int HOLD_MAX = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic [N_MST-1:0] m_req,
  output logic [N_MST-1:0] m_gnt,
  output logic [2:0]       owner,
  output logic             owner_vld,
  output logic [N_MST-1:0] m_busy,
  output logic [4:0]       hold_cnt
);

  localparam logic [4:0] HOLD_LAST = (HOLD_MAX == 0) ? 5'd0 : 5'(HOLD_MAX - 1);
  localparam logic [N_MST-1:0] ONE_HOT0 = {{(N_MST - 1){1'b0}}, 1'b1};

  arb_state_t       state_reg;
  logic [N_MST-1:0] gnt_reg;
  bus_mst_t         owner_reg;
  bus_mst_t         last_owner_reg;
  logic             owner_vld_reg;
  logic [4:0]       hold_cnt_reg;

  logic     pick_found;
  bus_mst_t pick_winner;
  bus_mst_t pick_start;
  logic     owner_req;
  logic     preempt_now;
  logic     do_grant;
  logic     go_idle;

  assign pick_start = bus_next_idx(last_owner_reg, N_MST);

  // In OWN the current owner is never a candidate: on release its req is low
  // anyway, on preemption it must be skipped.
  rr_pick #(.N(N_MST)) u_pick (
    .req     (m_req),
    .start   (pick_start),
    .excl    (owner_reg),
    .excl_en (state_reg == ARB_OWN),
    .found   (pick_found),
    .winner  (pick_winner)
  );

  assign owner_req   = |(m_req & gnt_reg);
  assign preempt_now = (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LAST);
  // A release coinciding with a hold-limit expiry is handled as a release.
  assign do_grant    = pick_found &&
                       ((state_reg == ARB_IDLE) || !owner_req || preempt_now);
  assign go_idle     = (state_reg == ARB_OWN) && !owner_req && !pick_found;

  // Arbitration FSM with registered grant, owner and hold counter.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_reg      <= ARB_IDLE;
      gnt_reg        <= '0;
      owner_reg      <= '0;
      last_owner_reg <= bus_mst_t'(N_MST - 1);
      owner_vld_reg  <= 1'b0;
      hold_cnt_reg   <= '0;
    end else if (do_grant) begin
      state_reg      <= ARB_OWN;
      gnt_reg        <= ONE_HOT0 << pick_winner;
      owner_reg      <= pick_winner;
      last_owner_reg <= pick_winner;
      owner_vld_reg  <= 1'b1;
      hold_cnt_reg   <= '0;
    end else if (go_idle) begin
      state_reg      <= ARB_IDLE;
      gnt_reg        <= '0;
      owner_vld_reg  <= 1'b0;
      hold_cnt_reg   <= '0;
    end else if ((state_reg == ARB_OWN) && (hold_cnt_reg != 5'd31)) begin
      hold_cnt_reg   <= hold_cnt_reg + 5'd1;
    end
  end

  assign m_gnt     = gnt_reg;
  assign owner     = owner_reg;
  assign owner_vld = owner_vld_reg;
  assign hold_cnt  = hold_cnt_reg;
  assign m_busy    = m_req & ~gnt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (HOLD_MAX 16, 4, 0) driven with the
// same requests, compared against a behavioural ownership model each cycle.
module tb_bus_arbiter;

  logic       cpu_clk = 1'b0;
  logic       cpu_rstn = 1'b0;
  logic [3:0] m_req = '0;

  logic [3:0] gnt_o  [3];
  logic [2:0] own_o  [3];
  logic       vld_o  [3];
  logic [3:0] busy_o [3];
  logic [4:0] hcnt_o [3];

  int total = 0;
  int bad   = 0;

  // Model state per instance: owner (-1 = none), last granted, cycles held.
  int hm   [3] = '{16, 4, 0};
  int mo   [3];
  int ml   [3];
  int mh   [3];
  int mout [3];

  logic [3:0] prev_req = '0;

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter #(.N_MST(4), .HOLD_MAX(16)) dut0 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .m_req(m_req), .m_gnt(gnt_o[0]),
    .owner(own_o[0]), .owner_vld(vld_o[0]), .m_busy(busy_o[0]), .hold_cnt(hcnt_o[0]));
  bus_arbiter #(.N_MST(4), .HOLD_MAX(4)) dut1 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .m_req(m_req), .m_gnt(gnt_o[1]),
    .owner(own_o[1]), .owner_vld(vld_o[1]), .m_busy(busy_o[1]), .hold_cnt(hcnt_o[1]));
  bus_arbiter #(.N_MST(4), .HOLD_MAX(0)) dut2 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .m_req(m_req), .m_gnt(gnt_o[2]),
    .owner(own_o[2]), .owner_vld(vld_o[2]), .m_busy(busy_o[2]), .hold_cnt(hcnt_o[2]));

  // ---------------- reference model ----------------
  function automatic int find_next(logic [3:0] req, int from, int skip);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (from + i) % 4;
      if (req[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mo[k] = -1; ml[k] = 3; mh[k] = 0; mout[k] = 0;
    end
  endtask

  task automatic model_step(logic [3:0] req);
    for (int k = 0; k < 3; k++) begin
      int w;
      w = find_next(req, ml[k] + 1, mo[k]);
      if (mo[k] < 0 || !req[mo[k]] || (hm[k] != 0 && mh[k] == hm[k] - 1)) begin
        if (w >= 0) begin
          mo[k] = w; ml[k] = w; mout[k] = w; mh[k] = 0;
        end else if (mo[k] >= 0 && !req[mo[k]]) begin
          mo[k] = -1; mh[k] = 0;
        end else if (mo[k] >= 0 && mh[k] < 31) begin
          mh[k]++;
        end
      end else if (mh[k] < 31) begin
        mh[k]++;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(int k);
    logic [3:0] g;
    g = '0;
    if (mo[k] >= 0) g[mo[k]] = 1'b1;
    return g;
  endfunction

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      logic [4:0] eh;
      eg = exp_gnt(k);
      eh = (mo[k] >= 0) ? 5'(mh[k]) : 5'd0;
      total++;
      if (gnt_o[k] !== eg) begin
        bad++; $display("FAIL %s gnt dut%0d got=%b want=%b", tag, k, gnt_o[k], eg);
      end
      total++;
      if (vld_o[k] !== (mo[k] >= 0)) begin
        bad++; $display("FAIL %s vld dut%0d got=%b want=%b", tag, k, vld_o[k], (mo[k] >= 0));
      end
      total++;
      if (hcnt_o[k] !== eh) begin
        bad++; $display("FAIL %s hold dut%0d got=%0d want=%0d", tag, k, hcnt_o[k], eh);
      end
      total++;
      if (busy_o[k] !== (m_req & ~eg)) begin
        bad++; $display("FAIL %s busy dut%0d got=%b want=%b", tag, k, busy_o[k], m_req & ~eg);
      end
      if (mo[k] >= 0) begin
        total++;
        if (own_o[k] !== 3'(mout[k])) begin
          bad++; $display("FAIL %s owner dut%0d got=%0d want=%0d", tag, k, own_o[k], mout[k]);
        end
      end
    end
  endtask

  // One bus cycle: drive request at negedge, advance model at posedge, check.
  task automatic cycle(logic [3:0] r, string tag);
    @(negedge cpu_clk);
    m_req = r;
    @(posedge cpu_clk);
    model_step(r);
    #1;
    check_all(tag);
    $display("cycle %s req=%b gnt=%b/%b/%b", tag, r, gnt_o[0], gnt_o[1], gnt_o[2]);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    m_req = '0;
    model_reset();
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  // ---------------- continuous invariants ----------------
  always @(posedge cpu_clk) prev_req <= m_req;

  always @(negedge cpu_clk) begin
    for (int k = 0; k < 3; k++) begin
      total++;
      if (!$onehot0(gnt_o[k]) || (vld_o[k] !== (|gnt_o[k]))) begin
        bad++; $display("FAIL inv_onehot dut%0d gnt=%b vld=%b", k, gnt_o[k], vld_o[k]);
      end
      total++;
      if ((gnt_o[k] & ~prev_req) != 4'b0000) begin
        bad++; $display("FAIL inv_gnt_no_req dut%0d gnt=%b req_prev=%b", k, gnt_o[k], prev_req);
      end
      total++;
      if (busy_o[k] !== (m_req & ~gnt_o[k])) begin
        bad++; $display("FAIL inv_busy dut%0d busy=%b want=%b", k, busy_o[k], m_req & ~gnt_o[k]);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    check_all("reset");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (own_o[k] !== 3'd0) begin
        bad++; $display("FAIL reset_owner dut%0d got=%0d want=0", k, own_o[k]);
      end
    end
    $display("reset released");
  endtask

  task automatic test_first_grant();
    cycle(4'b0011, "first");
    total++;
    if (gnt_o[0] !== 4'b0001 || own_o[0] !== 3'd0 || busy_o[0] !== 4'b0010) begin
      bad++; $display("FAIL first_grant gnt=%b owner=%0d busy=%b want 0001/0/0010",
                      gnt_o[0], own_o[0], busy_o[0]);
    end
  endtask

  task automatic test_release_handover();
    cycle(4'b0010, "release");
    total++;
    if (gnt_o[0] !== 4'b0010) begin
      bad++; $display("FAIL release_handover gnt=%b want=0010", gnt_o[0]);
    end
  endtask

  task automatic test_rr_order();
    logic [3:0] e;
    do_reset();
    cycle(4'b1111, "rr");
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      total++;
      if (gnt_o[0] !== e) begin
        bad++; $display("FAIL rr_order step%0d gnt=%b want=%b", g, gnt_o[0], e);
      end
      cycle(4'b1111, "rr");
      cycle(4'b1111, "rr");
      if (g < 4) cycle(4'b1111 & ~e, "rr_drop");
    end
  endtask

  task automatic test_preempt();
    do_reset();
    cycle(4'b0100, "pre");
    for (int i = 0; i < 3; i++) cycle(4'b0110, "pre");
    total++;
    if (gnt_o[1] !== 4'b0100 || hcnt_o[1] !== 5'd3) begin
      bad++; $display("FAIL preempt_hold gnt=%b hold=%0d want 0100/3", gnt_o[1], hcnt_o[1]);
    end
    cycle(4'b0110, "pre");
    total++;
    if (gnt_o[1] !== 4'b0010 || busy_o[1] !== 4'b0100) begin
      bad++; $display("FAIL preempt_move gnt=%b busy=%b want 0010/0100", gnt_o[1], busy_o[1]);
    end
  endtask

  task automatic test_unlimited();
    do_reset();
    cycle(4'b0001, "unl");
    for (int i = 0; i < 40; i++) cycle(4'b1111, "unl");
    total++;
    if (gnt_o[2] !== 4'b0001 || hcnt_o[2] !== 5'd31) begin
      bad++; $display("FAIL unlimited gnt=%b hold=%0d want 0001/31", gnt_o[2], hcnt_o[2]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge cpu_clk);
    #2;
    cpu_rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (gnt_o[k] !== 4'b0000 || vld_o[k] !== 1'b0) begin
        bad++; $display("FAIL async_reset dut%0d gnt=%b vld=%b want 0000/0", k, gnt_o[k], vld_o[k]);
      end
    end
    model_reset();
    m_req = '0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    cycle(4'b1000, "after_rst");
    total++;
    if (gnt_o[0] !== 4'b1000) begin
      bad++; $display("FAIL after_reset gnt=%b want=1000", gnt_o[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = '0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r, "rand");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_release_handover();
    test_rr_order();
    test_preempt();
    test_unlimited();
    test_async_reset();
    test_random();
    @(negedge cpu_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
